adc_multi_ch_sampler: RTL and testbench

Multi-channel DRP reader for the XADC wizard in continuous-sequencer mode. It sits between `xadc_wiz_0` and downstream consumers such as the FND display path and the servo duty mapper. It replaces the single-channel "den = eoc" hookup with a proper DRP read handshake. It captures up to NUM_CH auxiliary channels into per-channel result registers, with optional power-of-two averaging, overrun counting and DRDY timeout detection.

---
 rtl/adc_multi_ch_sampler_if.sv | 32 +++
 rtl/adc_multi_ch_sampler.sv | 211 +++++++++++++++++++++
 tb/tb_adc_multi_ch_sampler.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_multi_ch_sampler_if.sv
// adc_multi_ch_sampler_if: bundle of the XADC DRP handshake, the sample strobe
// and the result read port used by adc_multi_ch_sampler.
// master = the sampler itself, slave = the XADC / consumer side.
interface adc_multi_ch_sampler_if #(
    parameter int RES_BITS = 12
);
    logic                eoc_in;
    logic [4:0]          channel_in;
    logic                drdy_in;
    logic [15:0]         do_in;
    logic                den_out;
    logic [6:0]          daddr_out;
    logic                sample_valid;
    logic [2:0]          sample_ch;
    logic [RES_BITS-1:0] sample_val;
    logic [2:0]          rd_sel;
    logic [RES_BITS-1:0] rd_data;
    logic [7:0]          overrun_cnt;
    logic                err_timeout;

    modport master (
        input  eoc_in, channel_in, drdy_in, do_in, rd_sel,
        output den_out, daddr_out, sample_valid, sample_ch, sample_val,
               rd_data, overrun_cnt, err_timeout
    );

    modport slave (
        output eoc_in, channel_in, drdy_in, do_in, rd_sel,
        input  den_out, daddr_out, sample_valid, sample_ch, sample_val,
               rd_data, overrun_cnt, err_timeout
    );
endinterface

// File: rtl/adc_multi_ch_sampler.sv
// adc_multi_ch_sampler: multi-channel DRP reader for the XADC continuous
// sequencer. Each valid EOC triggers one DRP read; the result lands in a
// per-channel register. Define ADC_AVG_EN to average 2^AVG_LOG2 samples per
// published result (intermediate reads accumulate silently).
module adc_multi_ch_sampler #(
    parameter int         NUM_CH       = 2,
    parameter logic [4:0] CH_BASE      = 5'h16,
    parameter int         RES_BITS     = 12,
    parameter int         AVG_LOG2     = 3,
    parameter int         DRDY_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset_p,
    adc_multi_ch_sampler_if.master bus
);
    localparam int         TO_W     = $clog2(DRDY_TIMEOUT + 1);
    localparam logic [4:0] NUM_CH_W = 5'(NUM_CH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_STORE
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic                r_eoc;
    logic [4:0]          w_chOffset;
    logic                w_inRange;
    logic                w_validEdge;
    logic                w_den;
    logic                w_drdyHit;
    logic                w_timeout;
    logic [2:0]          r_idx;
    logic [6:0]          r_daddr;
    logic [TO_W-1:0]     r_waitCnt;
    logic [7:0]          r_overrun;
    logic                r_errTimeout;
    logic [RES_BITS-1:0] w_capture;
    logic [RES_BITS-1:0] r_result [NUM_CH];
    logic                r_sampleValid;
    logic [2:0]          r_sampleCh;
    logic [RES_BITS-1:0] r_sampleVal;
    logic [RES_BITS-1:0] w_rdData;
    logic                w_unusedBits;

    assign w_chOffset  = bus.channel_in - CH_BASE;
    assign w_inRange   = (bus.channel_in >= CH_BASE) && (w_chOffset < NUM_CH_W);
    assign w_validEdge = bus.eoc_in && !r_eoc && w_inRange;
    assign w_drdyHit   = (r_state == S_WAIT) && bus.drdy_in;
    assign w_timeout   = (r_state == S_WAIT) && !bus.drdy_in &&
                         (r_waitCnt == TO_W'(DRDY_TIMEOUT - 1));
    assign w_capture   = bus.do_in[15 -: RES_BITS];
    // Low do_in bits below the result width are deliberately discarded.
    assign w_unusedBits = ^{bus.do_in, 1'(AVG_LOG2)};

    // FSM state register; reset abandons any pending DRP read immediately.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) r_state <= S_IDLE;
        else         r_state <= w_nextState;
    end

    // Next-state logic and the one-cycle DRP enable in REQ.
    always_comb begin
        w_nextState = r_state;
        w_den       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_validEdge) w_nextState = S_REQ;
            end
            S_REQ: begin
                w_den       = 1'b1;
                w_nextState = S_WAIT;
            end
            S_WAIT: begin
                if (bus.drdy_in)    w_nextState = S_STORE;
                else if (w_timeout) w_nextState = S_IDLE;
            end
            S_STORE: begin
                w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // EOC edge history, channel latch and DRP address held until the next REQ.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_eoc   <= 1'b0;
            r_idx   <= 3'd0;
            r_daddr <= 7'd0;
        end else begin
            r_eoc <= bus.eoc_in;
            if (r_state == S_IDLE && w_validEdge) begin
                r_idx   <= w_chOffset[2:0];
                r_daddr <= {2'b00, bus.channel_in};
            end
        end
    end

    // DRDY wait counter, sticky timeout flag and saturating overrun count.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_waitCnt    <= '0;
            r_errTimeout <= 1'b0;
            r_overrun    <= 8'd0;
        end else begin
            if (r_state == S_REQ)       r_waitCnt <= '0;
            else if (r_state == S_WAIT) r_waitCnt <= r_waitCnt + TO_W'(1);
            if (w_timeout) r_errTimeout <= 1'b1;
            if (w_validEdge && r_state != S_IDLE && r_overrun != 8'hFF)
                r_overrun <= r_overrun + 8'd1;
        end
    end

`ifdef ADC_AVG_EN
    localparam int ACC_W = RES_BITS + AVG_LOG2;

    logic [ACC_W-1:0]    r_acc    [NUM_CH];
    logic [AVG_LOG2-1:0] r_avgCnt [NUM_CH];
    logic [ACC_W-1:0]    w_accSel;
    logic [AVG_LOG2-1:0] w_cntSel;
    logic [ACC_W-1:0]    w_sum;
    logic [RES_BITS-1:0] w_avg;
    logic                w_avgDone;

    // Running sum for the channel being read; done on its last sample.
    always_comb begin
        w_accSel = '0;
        w_cntSel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_idx == 3'(i)) begin
                w_accSel = r_acc[i];
                w_cntSel = r_avgCnt[i];
            end
        end
        w_sum     = w_accSel + ACC_W'(w_capture);
        w_avg     = RES_BITS'(w_sum >> AVG_LOG2);
        w_avgDone = (w_cntSel == '1);
    end

    // Accumulate each capture; publish the truncated mean on the last one.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i]    <= '0;
                r_avgCnt[i] <= '0;
                r_result[i] <= '0;
            end
            r_sampleValid <= 1'b0;
            r_sampleCh    <= 3'd0;
            r_sampleVal   <= '0;
        end else begin
            r_sampleValid <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_drdyHit && r_idx == 3'(i)) begin
                    if (w_avgDone) begin
                        r_result[i]   <= w_avg;
                        r_acc[i]      <= '0;
                        r_avgCnt[i]   <= '0;
                        r_sampleValid <= 1'b1;
                        r_sampleCh    <= r_idx;
                        r_sampleVal   <= w_avg;
                    end else begin
                        r_acc[i]    <= w_sum;
                        r_avgCnt[i] <= r_avgCnt[i] + AVG_LOG2'(1);
                    end
                end
            end
        end
    end
`else
    // Every capture is published raw; the strobe is high during STORE.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            for (int i = 0; i < NUM_CH; i++) r_result[i] <= '0;
            r_sampleValid <= 1'b0;
            r_sampleCh    <= 3'd0;
            r_sampleVal   <= '0;
        end else begin
            r_sampleValid <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_drdyHit && r_idx == 3'(i)) begin
                    r_result[i]   <= w_capture;
                    r_sampleValid <= 1'b1;
                    r_sampleCh    <= r_idx;
                    r_sampleVal   <= w_capture;
                end
            end
        end
    end
`endif

    // Read-port mux; selects beyond the configured channels read as zero.
    always_comb begin
        w_rdData = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.rd_sel == 3'(i)) w_rdData = r_result[i];
        end
    end

    assign bus.den_out      = w_den;
    assign bus.daddr_out    = r_daddr;
    assign bus.sample_valid = r_sampleValid;
    assign bus.sample_ch    = r_sampleCh;
    assign bus.sample_val   = r_sampleVal;
    assign bus.rd_data      = w_rdData;
    assign bus.overrun_cnt  = r_overrun;
    assign bus.err_timeout  = r_errTimeout;
endmodule

// File: tb/tb_adc_multi_ch_sampler.sv
// tb_adc_multi_ch_sampler: randomized DRP transactions against a reference
// model of per-channel results, overrun count and timeout flag. Expected
// samples go into a queue that a negedge monitor drains.
module tb_adc_multi_ch_sampler;
    localparam int         NUM_CH   = 2;
    localparam logic [4:0] CH_BASE  = 5'h16;
    localparam int         RES_BITS = 12;
`ifdef ADC_AVG_EN
    localparam int AVG_N = 8;
`else
    localparam int AVG_N = 1;
`endif

    logic clk = 1'b0;
    logic reset_p;
    int   assertCount = 0;
    int   failCount   = 0;

    logic [14:0] expQ [$];
    int modelSum [NUM_CH];
    int modelCnt [NUM_CH];
    int modelRes [NUM_CH];
    int modelOverrun;
    bit modelErr;

    adc_multi_ch_sampler_if #(.RES_BITS(RES_BITS)) bus ();

    adc_multi_ch_sampler #(
        .NUM_CH(NUM_CH), .CH_BASE(CH_BASE), .RES_BITS(RES_BITS),
        .AVG_LOG2(3), .DRDY_TIMEOUT(15)
    ) dut (
        .clk(clk),
        .reset_p(reset_p),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    function automatic bit isValidCh(input logic [4:0] ch);
        return (ch >= CH_BASE) && (int'(ch) < int'(CH_BASE) + NUM_CH);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NUM_CH; i++) begin
            modelSum[i] = 0;
            modelCnt[i] = 0;
            modelRes[i] = 0;
        end
        modelOverrun = 0;
        modelErr     = 1'b0;
        expQ.delete();
    endtask

    task automatic modelDrop();
        if (modelOverrun < 255) modelOverrun++;
    endtask

    // A completed read: average over AVG_N captures, publish when complete.
    task automatic modelStore(input int lch, input logic [15:0] data, output bit emit);
        modelSum[lch] += int'(data[15:4]);
        modelCnt[lch]++;
        emit = 1'b0;
        if (modelCnt[lch] == AVG_N) begin
            modelRes[lch] = modelSum[lch] / AVG_N;
            expQ.push_back({3'(lch), 12'(modelRes[lch])});
            modelSum[lch] = 0;
            modelCnt[lch] = 0;
            emit = 1'b1;
        end
    endtask

    // Compare read port for every select (2 is out of range), overrun, error.
    task automatic checkState();
        for (int i = 0; i < 3; i++) begin
            bus.rd_sel = 3'(i);
            #1;
            checkOutput($sformatf("rdData%0d", i), 32'(bus.rd_data),
                        (i < NUM_CH) ? 32'(modelRes[i]) : 32'd0);
        end
        checkOutput("overrunCnt", 32'(bus.overrun_cnt), 32'(modelOverrun));
        checkOutput("errTimeout", 32'(bus.err_timeout), 32'(modelErr));
    endtask

    // One EOC on channel ch; optional extra EOCs during WAIT; drdy after delay.
    task automatic applyStimulus(input logic [4:0] ch, input logic [15:0] data,
                                 input int delay, input int extra,
                                 input bit randomPulses, input bit eocAtStore);
        bit          emit;
        bit          sawDen;
        logic [4:0]  pc;
        @(posedge clk); #1;
        bus.eoc_in     = 1'b1;
        bus.channel_in = ch;
        @(posedge clk); #1;
        bus.eoc_in = 1'b0;
        @(negedge clk);
        if (!isValidCh(ch)) begin
            sawDen = bus.den_out;
            repeat (4) begin
                @(negedge clk);
                sawDen = sawDen | bus.den_out;
            end
            checkOutput("denIgnored", 32'(sawDen), 32'd0);
            @(posedge clk); #1;
            checkState();
            return;
        end
        checkOutput("denPulse", 32'(bus.den_out), 32'd1);
        checkOutput("daddr", 32'(bus.daddr_out), 32'({2'b00, ch}));
        for (int k = 0; k < extra; k++) begin
            pc = randomPulses ? 5'(5'h14 + $urandom_range(0, 5)) : CH_BASE;
            @(posedge clk); #1;
            bus.eoc_in     = 1'b1;
            bus.channel_in = pc;
            if (isValidCh(pc)) modelDrop();
            @(posedge clk); #1;
            bus.eoc_in = 1'b0;
        end
        repeat (delay - 1) @(posedge clk);
        @(posedge clk); #1;
        bus.drdy_in = 1'b1;
        bus.do_in   = data;
        modelStore(int'(ch) - int'(CH_BASE), data, emit);
        @(posedge clk); #1;
        bus.drdy_in = 1'b0;
        bus.do_in   = 16'($urandom);
        if (eocAtStore) begin
            bus.eoc_in     = 1'b1;
            bus.channel_in = CH_BASE;
            modelDrop();
        end
        @(negedge clk);
        checkOutput("sampleValidStrobe", 32'(bus.sample_valid), 32'(emit));
        @(posedge clk); #1;
        bus.eoc_in = 1'b0;
        @(negedge clk);
        checkOutput("denIdle", 32'(bus.den_out), 32'd0);
        @(posedge clk); #1;
        checkState();
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected sample.
    always @(negedge clk) begin
        logic [14:0] e;
        if (!reset_p && bus.sample_valid) begin
            if (expQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpectedSample: got ch %0d val 0x%0h, expected none at %0t",
                         bus.sample_ch, bus.sample_val, $time);
            end else begin
                e = expQ.pop_front();
                checkOutput("sampleCh", 32'(bus.sample_ch), 32'(e[14:12]));
                checkOutput("sampleVal", 32'(bus.sample_val), 32'(e[11:0]));
            end
        end
    end

    initial begin
        reset_p        = 1'b1;
        bus.eoc_in     = 1'b0;
        bus.channel_in = 5'd0;
        bus.drdy_in    = 1'b0;
        bus.do_in      = 16'd0;
        bus.rd_sel     = 3'd0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        reset_p = 1'b0;
        @(negedge clk);
        checkOutput("rstDen", 32'(bus.den_out), 32'd0);
        checkOutput("rstDaddr", 32'(bus.daddr_out), 32'd0);
        checkOutput("rstSampleValid", 32'(bus.sample_valid), 32'd0);
        checkOutput("rstSampleCh", 32'(bus.sample_ch), 32'd0);
        checkOutput("rstSampleVal", 32'(bus.sample_val), 32'd0);
        @(posedge clk); #1;
        checkState();

        $display("[TB] raw capture and interleaved channels");
        applyStimulus(5'h16, 16'hABC0, 1, 0, 1'b0, 1'b0);
        applyStimulus(5'h16, 16'h1230, 1, 0, 1'b0, 1'b0);
        applyStimulus(5'h17, 16'h4560, 2, 0, 1'b0, 1'b0);

        $display("[TB] out-of-range channels");
        applyStimulus(5'h03, 16'h7770, 1, 0, 1'b0, 1'b0);
        applyStimulus(5'h18, 16'h7770, 1, 0, 1'b0, 1'b0);

        $display("[TB] overrun during WAIT and at STORE");
        applyStimulus(5'h16, 16'h5550, 1, 1, 1'b0, 1'b0);
        applyStimulus(5'h17, 16'h6660, 1, 0, 1'b0, 1'b1);

        $display("[TB] stray drdy while idle");
        @(posedge clk); #1;
        bus.drdy_in = 1'b1;
        bus.do_in   = 16'hFFF0;
        @(posedge clk); #1;
        bus.drdy_in = 1'b0;
        @(negedge clk);
        checkOutput("strayDrdyValid", 32'(bus.sample_valid), 32'd0);
        @(posedge clk); #1;
        checkState();

        $display("[TB] randomized reads");
        for (int n = 0; n < 40; n++) begin
            applyStimulus(5'(5'h14 + $urandom_range(0, 5)), 16'($urandom),
                          int'($urandom_range(1, 4)), int'($urandom_range(0, 5)),
                          1'b1, 1'($urandom_range(0, 1)));
        end

        $display("[TB] overrun saturation");
        for (int n = 0; n < 60; n++) begin
            applyStimulus(5'(CH_BASE + 5'($urandom_range(0, 1))), 16'($urandom),
                          int'($urandom_range(1, 4)), 5, 1'b0, 1'b0);
        end

        $display("[TB] drdy timeout");
        @(posedge clk); #1;
        bus.eoc_in     = 1'b1;
        bus.channel_in = 5'h16;
        @(posedge clk); #1;
        bus.eoc_in = 1'b0;
        @(negedge clk);
        checkOutput("timeoutDen", 32'(bus.den_out), 32'd1);
        repeat (15) @(negedge clk);
        checkOutput("errBeforeLimit", 32'(bus.err_timeout), 32'd0);
        @(negedge clk);
        checkOutput("errAtLimit", 32'(bus.err_timeout), 32'd1);
        modelErr = 1'b1;
        @(posedge clk); #1;
        checkState();
        applyStimulus(5'h17, 16'($urandom), 2, 0, 1'b0, 1'b0);

        $display("[TB] reset during WAIT");
        @(posedge clk); #1;
        bus.eoc_in     = 1'b1;
        bus.channel_in = 5'h17;
        @(posedge clk); #1;
        bus.eoc_in = 1'b0;
        @(negedge clk);
        checkOutput("midResetDen", 32'(bus.den_out), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        reset_p = 1'b1;
        modelReset();
        #1;
        checkOutput("asyncResetOverrun", 32'(bus.overrun_cnt), 32'd0);
        @(posedge clk); #1;
        reset_p     = 1'b0;
        bus.drdy_in = 1'b1;
        bus.do_in   = 16'hFFF0;
        @(posedge clk); #1;
        bus.drdy_in = 1'b0;
        @(negedge clk);
        checkOutput("lateDrdyValid", 32'(bus.sample_valid), 32'd0);
        checkOutput("postRstSampleCh", 32'(bus.sample_ch), 32'd0);
        checkOutput("postRstSampleVal", 32'(bus.sample_val), 32'd0);
        checkOutput("postRstDaddr", 32'(bus.daddr_out), 32'd0);
        checkOutput("postRstDen", 32'(bus.den_out), 32'd0);
        @(posedge clk); #1;
        checkState();

        $display("[TB] averaging sequence on channel 0");
        for (int n = 0; n < 8; n++) begin
            applyStimulus(5'h16, 16'((100 + n) << 4), 1, 0, 1'b0, 1'b0);
        end

        repeat (4) @(posedge clk);
        #1;
        checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end
endmodule
